// File: rtl/sprite_dma.sv
// Sprite/object buffer DMA: copies a byte block from a one-cycle-latency source
// into the buffer RAM's port A, or fills a region of it with a constant.
//
// state | meaning
// IDLE  | waiting for start; transfer parameters latched on start
// RD    | source read request presented, held while src_wait is high
// WR    | returned source byte written to the destination
// FILL  | constant written to the destination, one byte per cycle
// DONE  | one-cycle completion pulse
module sprite_dma #(
    parameter int addr_width_g = 8,
    parameter int data_width_g = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      fill_mode,
    input  logic [data_width_g-1:0]   fill_value,
    input  logic [15:0]               src_base,
    input  logic [addr_width_g-1:0]   dst_base,
    input  logic [addr_width_g:0]     len,
    output logic                      src_rd,
    output logic [15:0]               src_addr,
    input  logic                      src_wait,
    input  logic [data_width_g-1:0]   src_data,
    output logic                      dst_enable,
    output logic                      dst_wren,
    output logic [addr_width_g-1:0]   dst_address,
    output logic [data_width_g-1:0]   dst_data,
    output logic                      busy,
    output logic                      done
);

    localparam int cnt_width_c = addr_width_g + 1;

    typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

    state_t                    state, state_n;
    logic [cnt_width_c-1:0]    cnt, cnt_n, cnt_inc;
    logic [cnt_width_c-1:0]    len_q, len_n, len_eff;
    logic [15:0]               src_base_q, src_base_n;
    logic [addr_width_g-1:0]   dst_base_q, dst_base_n;
    logic [data_width_g-1:0]   fill_q, fill_n;

    logic                      src_rd_n;
    logic [15:0]               src_addr_n;
    logic                      dst_wr_n;
    logic [addr_width_g-1:0]   dst_address_n;

    // Counts above the buffer size are clamped to one full pass of the buffer.
    assign len_eff = len[addr_width_g] ? {1'b1, {addr_width_g{1'b0}}} : len;
    assign cnt_inc = cnt + cnt_width_c'(1);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        len_n      = len_q;
        src_base_n = src_base_q;
        dst_base_n = dst_base_q;
        fill_n     = fill_q;
        case (state)
            IDLE: begin
                if (start) begin
                    len_n      = len_eff;
                    src_base_n = src_base;
                    dst_base_n = dst_base;
                    fill_n     = fill_value;
                    cnt_n      = '0;
                    if (len_eff == '0)
                        state_n = DONE;
                    else if (fill_mode)
                        state_n = FILL;
                    else
                        state_n = RD;
                end
            end
            RD: begin
                if (!src_wait)
                    state_n = WR;
            end
            WR: begin
                cnt_n   = cnt_inc;
                state_n = (cnt_inc == len_q) ? DONE : RD;
            end
            FILL: begin
                cnt_n   = cnt_inc;
                state_n = (cnt_inc == len_q) ? DONE : FILL;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Strobes and addresses are registered from the next state so they line up
    // with the cycle that state is occupied.
    always_comb begin
        src_rd_n      = (state_n == RD);
        src_addr_n    = src_rd_n ? (src_base_n + 16'(cnt_n)) : 16'h0000;
        dst_wr_n      = (state_n == WR) || (state_n == FILL);
        dst_address_n = dst_wr_n ? (dst_base_n + cnt_n[addr_width_g-1:0]) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            len_q       <= '0;
            src_base_q  <= '0;
            dst_base_q  <= '0;
            fill_q      <= '0;
            src_rd      <= 1'b0;
            src_addr    <= '0;
            dst_enable  <= 1'b0;
            dst_wren    <= 1'b0;
            dst_address <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            len_q       <= len_n;
            src_base_q  <= src_base_n;
            dst_base_q  <= dst_base_n;
            fill_q      <= fill_n;
            src_rd      <= src_rd_n;
            src_addr    <= src_addr_n;
            dst_enable  <= dst_wr_n;
            dst_wren    <= dst_wr_n;
            dst_address <= dst_address_n;
            busy        <= src_rd_n || dst_wr_n;
            done        <= (state_n == DONE);
        end
    end

    // Copy data passes straight through; the source holds it for the whole WR cycle.
    assign dst_data = (state == WR)   ? src_data :
                      (state == FILL) ? fill_q   : '0;

endmodule

// File: tb/tb_sprite_dma.sv
// Directed bench for sprite_dma: copy, stalled copy, fill, clamping, zero length,
// source wrap, reset abort, ignored starts and back-to-back restart.
module tb_sprite_dma;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        fill_mode = 1'b0;
    logic [7:0]  fill_value = 8'h00;
    logic [15:0] src_base = 16'h0000;
    logic [7:0]  dst_base = 8'h00;
    logic [8:0]  len = 9'd0;
    logic        src_wait = 1'b0;
    logic [7:0]  src_data;
    logic        src_rd;
    logic [15:0] src_addr;
    logic        dst_enable;
    logic        dst_wren;
    logic [7:0]  dst_address;
    logic [7:0]  dst_data;
    logic        busy;
    logic        done;

    sprite_dma #(.addr_width_g(8), .data_width_g(8)) dut (
        .clock(clock), .reset(reset), .start(start), .fill_mode(fill_mode),
        .fill_value(fill_value), .src_base(src_base), .dst_base(dst_base), .len(len),
        .src_rd(src_rd), .src_addr(src_addr), .src_wait(src_wait), .src_data(src_data),
        .dst_enable(dst_enable), .dst_wren(dst_wren), .dst_address(dst_address),
        .dst_data(dst_data), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Source memory: data valid only in the cycle after an accepted read.
    logic [7:0] smem [0:65535];
    always @(posedge clock) begin
        if (src_rd && !src_wait)
            src_data <= smem[src_addr];
        else
            src_data <= 8'hEE;
    end

    int vectors = 0;
    int miscompares = 0;

    int wq_cyc[$], wq_addr[$], wq_data[$];
    int rq_cyc[$], rq_addr[$];
    int busy_first, busy_last, busy_cnt, done_cyc, done_cnt, wren_bad, dirty;

    // Pulses start with the given parameters, scrambles the inputs afterwards and
    // logs every cycle relative to the start edge until the cycle after done.
    task automatic run(input logic fm, input logic [7:0] fv, input logic [15:0] sb,
                       input logic [7:0] db, input logic [8:0] ln, input int wf, input int wt,
                       input int rst_at, input int sa1, input int sa2, input int maxc);
        wq_cyc.delete(); wq_addr.delete(); wq_data.delete();
        rq_cyc.delete(); rq_addr.delete();
        busy_first = 0; busy_last = 0; busy_cnt = 0;
        done_cyc = 0; done_cnt = 0; wren_bad = 0; dirty = 0;
        fill_mode = fm; fill_value = fv; src_base = sb; dst_base = db; len = ln;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0; fill_mode = ~fm; fill_value = 8'hDE;
        src_base = 16'hBEEF; dst_base = 8'h55; len = 9'd7;
        for (int r = 1; r <= maxc; r++) begin
            @(negedge clock);
            if (dst_enable) begin
                wq_cyc.push_back(r);
                wq_addr.push_back(int'(dst_address));
                wq_data.push_back(int'(dst_data));
                if (!dst_wren) wren_bad++;
            end
            if (src_rd) begin
                rq_cyc.push_back(r);
                rq_addr.push_back(int'(src_addr));
            end
            if (busy) begin
                if (busy_first == 0) busy_first = r;
                busy_last = r;
                busy_cnt++;
            end
            if (done) begin
                if (done_cyc == 0) done_cyc = r;
                done_cnt++;
            end
            if (rst_at > 0 && r > rst_at &&
                (src_rd !== 1'b0 || dst_enable !== 1'b0 || dst_wren !== 1'b0 ||
                 busy !== 1'b0 || done !== 1'b0 || src_addr !== 16'h0 ||
                 dst_address !== 8'h0 || dst_data !== 8'h0))
                dirty++;
            src_wait = (r >= wf && r < wt);
            start = (r == sa1 || r == sa2);
            if (r == rst_at) reset = 1'b1;
            if (done_cyc > 0 && r == done_cyc + 1) break;
            if (rst_at > 0 && r == rst_at + 3) break;
        end
        start = 1'b0;
        src_wait = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; fill_mode = 1'b1; len = 9'd5; src_wait = 1'b1;
        @(posedge clock);
        @(negedge clock);
        vectors++;
        if ({src_rd, dst_enable, dst_wren, busy, done} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_strobes got %b exp 00000", {src_rd, dst_enable, dst_wren, busy, done});
        end
        vectors++;
        if (src_addr !== 16'h0 || dst_address !== 8'h0 || dst_data !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_buses got src_addr %h dst_address %h dst_data %h exp 0 0 0",
                     src_addr, dst_address, dst_data);
        end
        @(negedge clock);
        reset = 1'b0; start = 1'b0; src_wait = 1'b0;
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || src_rd !== 1'b0 || dst_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle got busy %b src_rd %b dst_enable %b exp 0 0 0", busy, src_rd, dst_enable);
        end
    endtask

    task automatic test_copy_basic();
        run(1'b0, 8'h00, 16'h1000, 8'h10, 9'd4, 0, 0, -1, -1, -1, 40);
        vectors++;
        if (wq_cyc.size() != 4 || rq_cyc.size() != 4) begin
            miscompares++;
            $display("FAIL copy_counts got writes %0d reads %0d exp 4 4", wq_cyc.size(), rq_cyc.size());
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (k >= wq_cyc.size() || k >= rq_cyc.size()) begin
                miscompares++;
                $display("FAIL copy_xfer%0d got none exp write at cycle %0d", k, 2*k+2);
            end else if (rq_cyc[k] != 2*k+1 || rq_addr[k] != 'h1000+k || wq_cyc[k] != 2*k+2 ||
                         wq_addr[k] != 'h10+k || wq_data[k] != 'hA0+k) begin
                miscompares++;
                $display("FAIL copy_xfer%0d got rd %0d@%h wr %0d@%h=%h exp rd %0d@%h wr %0d@%h=%h",
                         k, rq_cyc[k], rq_addr[k], wq_cyc[k], wq_addr[k], wq_data[k],
                         2*k+1, 'h1000+k, 2*k+2, 'h10+k, 'hA0+k);
            end
        end
        vectors++;
        if (done_cyc != 9 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL copy_done got cycle %0d count %0d exp 9 1", done_cyc, done_cnt);
        end
        vectors++;
        if (busy_first != 1 || busy_last != 8 || busy_cnt != 8 || wren_bad != 0) begin
            miscompares++;
            $display("FAIL copy_busy got first %0d last %0d count %0d wren_bad %0d exp 1 8 8 0",
                     busy_first, busy_last, busy_cnt, wren_bad);
        end
    endtask

    task automatic test_copy_wait();
        int erc [7] = '{1, 3, 4, 5, 6, 8, 10};
        int era [7] = '{'h1000, 'h1001, 'h1001, 'h1001, 'h1001, 'h1002, 'h1003};
        int ewc [4] = '{2, 7, 9, 11};
        run(1'b0, 8'h00, 16'h1000, 8'h10, 9'd4, 3, 6, -1, -1, -1, 40);
        vectors++;
        if (rq_cyc.size() != 7) begin
            miscompares++;
            $display("FAIL wait_reads got %0d exp 7", rq_cyc.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                vectors++;
                if (rq_cyc[k] != erc[k] || rq_addr[k] != era[k]) begin
                    miscompares++;
                    $display("FAIL wait_rd%0d got %0d@%h exp %0d@%h", k, rq_cyc[k], rq_addr[k], erc[k], era[k]);
                end
            end
        end
        vectors++;
        if (wq_cyc.size() != 4) begin
            miscompares++;
            $display("FAIL wait_writes got %0d exp 4", wq_cyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (wq_cyc[k] != ewc[k] || wq_addr[k] != 'h10+k || wq_data[k] != 'hA0+k) begin
                    miscompares++;
                    $display("FAIL wait_wr%0d got %0d@%h=%h exp %0d@%h=%h",
                             k, wq_cyc[k], wq_addr[k], wq_data[k], ewc[k], 'h10+k, 'hA0+k);
                end
            end
        end
        vectors++;
        if (done_cyc != 12) begin
            miscompares++;
            $display("FAIL wait_done got %0d exp 12", done_cyc);
        end
    endtask

    task automatic test_fill_full();
        run(1'b1, 8'h00, 16'h0000, 8'h80, 9'd256, 0, 0, -1, -1, -1, 300);
        vectors++;
        if (wq_cyc.size() != 256 || rq_cyc.size() != 0) begin
            miscompares++;
            $display("FAIL fill_counts got writes %0d reads %0d exp 256 0", wq_cyc.size(), rq_cyc.size());
        end else begin
            for (int k = 0; k < 256; k++) begin
                vectors++;
                if (wq_cyc[k] != k+1 || wq_addr[k] != ((k + 'h80) & 'hFF) || wq_data[k] != 0) begin
                    miscompares++;
                    $display("FAIL fill_wr%0d got %0d@%h=%h exp %0d@%h=00",
                             k, wq_cyc[k], wq_addr[k], wq_data[k], k+1, (k + 'h80) & 'hFF);
                end
            end
        end
        vectors++;
        if (done_cyc != 257 || busy_cnt != 256) begin
            miscompares++;
            $display("FAIL fill_done got done %0d busy cycles %0d exp 257 256", done_cyc, busy_cnt);
        end
    endtask

    task automatic test_fill_clamp();
        run(1'b1, 8'h3C, 16'h0000, 8'hFE, 9'd300, 0, 0, -1, -1, -1, 300);
        vectors++;
        if (wq_cyc.size() != 256) begin
            miscompares++;
            $display("FAIL clamp_writes got %0d exp 256", wq_cyc.size());
        end else begin
            for (int k = 0; k < 256; k++) begin
                vectors++;
                if (wq_cyc[k] != k+1 || wq_addr[k] != ((k + 'hFE) & 'hFF) || wq_data[k] != 'h3C) begin
                    miscompares++;
                    $display("FAIL clamp_wr%0d got %0d@%h=%h exp %0d@%h=3c",
                             k, wq_cyc[k], wq_addr[k], wq_data[k], k+1, (k + 'hFE) & 'hFF);
                end
            end
        end
        vectors++;
        if (done_cyc != 257) begin
            miscompares++;
            $display("FAIL clamp_done got %0d exp 257", done_cyc);
        end
    endtask

    task automatic test_len_zero();
        for (int m = 0; m < 2; m++) begin
            run(m[0], 8'h99, 16'h1000, 8'h10, 9'd0, 0, 0, -1, -1, -1, 20);
            vectors++;
            if (wq_cyc.size() != 0 || rq_cyc.size() != 0 || busy_cnt != 0 || done_cyc != 1) begin
                miscompares++;
                $display("FAIL len0_mode%0d got writes %0d reads %0d busy %0d done %0d exp 0 0 0 1",
                         m, wq_cyc.size(), rq_cyc.size(), busy_cnt, done_cyc);
            end
        end
    endtask

    task automatic test_src_wrap();
        run(1'b0, 8'h00, 16'hFFFF, 8'h00, 9'd2, 0, 0, -1, -1, -1, 20);
        vectors++;
        if (rq_addr.size() != 2 || wq_data.size() != 2) begin
            miscompares++;
            $display("FAIL wrap_counts got reads %0d writes %0d exp 2 2", rq_addr.size(), wq_data.size());
        end else if (rq_addr[0] != 'hFFFF || rq_addr[1] != 0 || wq_data[0] != 'h5A ||
                     wq_data[1] != 'hC3 || wq_addr[1] != 1) begin
            miscompares++;
            $display("FAIL wrap_xfer got rd %h,%h data %h,%h addr1 %h exp ffff,0000 5a,c3 01",
                     rq_addr[0], rq_addr[1], wq_data[0], wq_data[1], wq_addr[1]);
        end
        vectors++;
        if (done_cyc != 5) begin
            miscompares++;
            $display("FAIL wrap_done got %0d exp 5", done_cyc);
        end
    endtask

    task automatic test_start_while_busy();
        run(1'b0, 8'h00, 16'h1000, 8'h10, 9'd4, 0, 0, -1, 3, 9, 40);
        vectors++;
        if (wq_cyc.size() != 4 || rq_cyc.size() != 4 || done_cyc != 9) begin
            miscompares++;
            $display("FAIL busy_start got writes %0d reads %0d done %0d exp 4 4 9",
                     wq_cyc.size(), rq_cyc.size(), done_cyc);
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (wq_addr[k] != 'h10+k || wq_data[k] != 'hA0+k || rq_addr[k] != 'h1000+k) begin
                    miscompares++;
                    $display("FAIL busy_start_wr%0d got %h=%h rd %h exp %h=%h rd %h",
                             k, wq_addr[k], wq_data[k], rq_addr[k], 'h10+k, 'hA0+k, 'h1000+k);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        run(1'b1, 8'h77, 16'h0000, 8'h20, 9'd10, 0, 0, 5, -1, -1, 40);
        reset = 1'b0;
        vectors++;
        if (wq_cyc.size() != 5 || (wq_cyc.size() == 5 && (wq_addr[4] != 'h24 || wq_cyc[4] != 5))) begin
            miscompares++;
            $display("FAIL rst_mid_writes got %0d exp 5 ending at 24 in cycle 5", wq_cyc.size());
        end
        vectors++;
        if (dirty != 0 || done_cnt != 0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs got active cycles %0d done %0d exp 0 0", dirty, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        run(1'b1, 8'h11, 16'h0000, 8'h40, 9'd2, 0, 0, -1, -1, -1, 20);
        vectors++;
        if (done_cyc != 3 || wq_cyc.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_first got done %0d writes %0d exp 3 2", done_cyc, wq_cyc.size());
        end
        run(1'b0, 8'h00, 16'h1002, 8'h90, 9'd1, 0, 0, -1, -1, -1, 20);
        vectors++;
        if (done_cyc != 3 || wq_cyc.size() != 1 || rq_cyc.size() != 1) begin
            miscompares++;
            $display("FAIL b2b_second got done %0d writes %0d reads %0d exp 3 1 1",
                     done_cyc, wq_cyc.size(), rq_cyc.size());
        end else if (wq_cyc[0] != 2 || wq_addr[0] != 'h90 || wq_data[0] != 'hA2 || rq_addr[0] != 'h1002) begin
            miscompares++;
            $display("FAIL b2b_second_xfer got %0d@%h=%h rd %h exp 2@90=a2 rd 1002",
                     wq_cyc[0], wq_addr[0], wq_data[0], rq_addr[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) smem[i] = 8'(i * 7 + 3);
        smem[16'h1000] = 8'hA0;
        smem[16'h1001] = 8'hA1;
        smem[16'h1002] = 8'hA2;
        smem[16'h1003] = 8'hA3;
        smem[16'hFFFF] = 8'h5A;
        smem[16'h0000] = 8'hC3;
        test_reset();
        test_copy_basic();
        test_copy_wait();
        test_fill_full();
        test_fill_clamp();
        test_len_zero();
        test_src_wrap();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sprite_dma.md
# sprite_dma

Single-clock DMA engine that loads a sprite/object buffer held in a dual-port block RAM, writing through the buffer's port A, typically during vblank. It copies a byte block from a CPU-side source memory with fixed one-cycle read latency, or fills a region with a constant to clear it. It sits between the main-CPU bus arbiter (source side) and the buffer RAM's port A. Port B remains free for the video scanner.

## Interface
- addr_width_g, 8: destination (buffer RAM) address width.
- data_width_g, 8: data width of the source and destination.
- clock  in  1  system clock; every register updates on its rising edge.
- reset  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle request; only acted on in IDLE.
- fill_mode  in  1  sampled with start: 0 selects copy, 1 selects constant fill.
- fill_value  in  data_width_g  constant to write; sampled with start.
- src_base  in  16  first source address; sampled with start.
- dst_base  in  addr_width_g  first destination address; sampled with start.
- len  in  addr_width_g+1  byte count; sampled with start.
- src_rd  out  1  source read request.
- src_addr  out  16  source read address.
- src_wait  in  1  source busy; holds the current read request.
- src_data  in  data_width_g  source data, valid the cycle after an accepted read.
- dst_enable  out  1  destination port enable.
- dst_wren  out  1  destination write enable.
- dst_address  out  addr_width_g  destination address.
- dst_data  out  data_width_g  destination write data.
- busy  out  1  high from the first RD/FILL cycle through the last write cycle.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RD, WR, FILL, DONE.
- IDLE, start=1:
  - Latch src_base, dst_base, fill_value and len_eff = min(len, 2^addr_width_g).
  - Clear the counter cnt (width addr_width_g+1).
  - Next state: DONE if len_eff=0; else FILL if fill_mode=1; else RD.
- RD state:
  - src_rd=1, src_addr=src_base+cnt (mod 2^16).
  - src_wait=1: stay in RD with the same address; no other change.
  - src_wait=0: the read is accepted; next state is WR.
- WR state:
  - dst_enable=dst_wren=1, dst_address=(dst_base+cnt) mod 2^addr_width_g.
  - dst_data=src_data, passed combinationally; the source holds it valid for the whole cycle.
  - Then cnt+1. Next state: DONE if cnt+1=len_eff, else RD.
- FILL state:
  - Writes one byte per cycle: dst_enable=dst_wren=1, dst_address as in WR, dst_data=fill_value.
  - Then cnt+1. Next state: DONE when cnt+1=len_eff, else stay in FILL.
  - src_wait is ignored.
- DONE state: done=1, busy=0; next state is IDLE.
- start outside IDLE (busy or DONE) is ignored and not queued.
- Destination addresses wrap modulo 2^addr_width_g.
- Source addresses wrap 0xFFFF to 0x0000.
- Inactive outputs are driven 0: src_rd, src_addr, dst_enable, dst_wren, dst_address and dst_data outside their active states.

## Timing
- Reset: state=IDLE. All outputs read 0 from the first edge with reset=1, including busy, done and every strobe.
- Reset takes priority over start and over any state. An in-flight transfer is abandoned with no further writes; RAM contents already written stay as they are.
- Start sampled on edge E:
  - First RD or FILL cycle is the cycle after E; busy is high from that cycle.
  - For len_eff=0, done rises in the cycle after E and busy never rises.
- Copy mode: 2 cycles per byte plus stall cycles.
  - The last write occurs in cycle 2·len_eff + stalls after E.
  - done is high the following cycle.
- Fill mode: write k (k=0..len_eff-1) occurs in cycle k+1 after E; done is high in cycle len_eff+1.
- The earliest accepted restart is the start sampled on the DONE→IDLE edge plus one, i.e. start asserted in the cycle after done.

## Test plan
- Copy, len=4, src_base=0x1000, dst_base=0x10, source bytes A0..A3, no wait:
  - Writes 0x10..0x13 = A0..A3 in cycles 2,4,6,8 after start.
  - done in cycle 9; busy high cycles 1–8.
- Copy with src_wait held 3 cycles on the second read:
  - src_addr held at 0x1001 for 4 cycles.
  - Data is still correct; done is delayed by exactly 3 cycles.
- Fill, len=256 (full), fill_value=0x00, dst_base=0x80:
  - 256 consecutive write cycles at 0x80..0xFF then 0x00..0x7F.
  - done in cycle 257.
- len=0 in both modes:
  - No src_rd and no write.
  - done in cycle 1 after start; busy stays 0.
- Source wrap: src_base=0xFFFF, len=2 → reads at 0xFFFF then 0x0000.
- Reset asserted during fill cycle 5 of 10:
  - No writes after the reset edge; all outputs 0.
- Start pulsed while busy: ignored, and the transfer completes unchanged.
- A new start in the cycle after done is accepted.
